backlight_ctrl: RTL

LCD backlight sequencer sitting in front of the 8-bit PWM generator. It owns the backlight enable pin and the PWM duty input. It performs the power-up delay, then ramps duty smoothly to a commanded brightness at a commanded rate, and ramps back to zero before dropping the enable. Brightness commands arrive from the SPI register decoder over a valid/ready handshake.

---
 rtl/backlight_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/backlight_ctrl.sv
// backlight_ctrl
//   LCD backlight sequencer in front of an 8-bit PWM generator. Applies the
//   power-up delay, ramps the PWM duty to a commanded brightness at a commanded
//   rate, and ramps back to zero before dropping the backlight enable.
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_en         level, 1 = backlight requested on
//   i_cmd_valid  brightness command valid
//   o_cmd_ready  command accepted when valid && ready at a rising edge
//   i_cmd_level  target duty
//   i_cmd_rate   ticks per ramp step, 0 = one step per clock
//   o_duty       registered duty to the PWM generator
//   o_bl_en      registered backlight driver enable
//   o_busy       high while powering up, ramping or powering down
//   o_done       one-cycle pulse when duty reaches the target
module backlight_ctrl #(
  parameter int unsigned P_TICK_DIV = 40000,
  parameter int unsigned P_ON_DLY   = 10,
  parameter int unsigned P_STEP     = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [7:0] i_cmd_level,
  input  logic [3:0] i_cmd_rate,
  output logic [7:0] o_duty,
  output logic       o_bl_en,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned TbW  = $clog2(P_TICK_DIV);
  localparam int unsigned DlyW = $clog2(P_ON_DLY + 1);

  localparam logic [TbW-1:0]  TbLast  = TbW'(P_TICK_DIV - 1);
  localparam logic [DlyW-1:0] DlyLast = DlyW'(P_ON_DLY - 1);
  localparam logic [8:0]      Step9   = 9'(P_STEP);

  typedef enum logic [2:0] {
    StOff,
    StPwrup,
    StRamp,
    StHold,
    StPwrdn
  } state_e;

  state_e          state_q;
  logic [TbW-1:0]  tb_cnt_q;
  logic [DlyW-1:0] dly_cnt_q;
  logic [3:0]      step_cnt_q;
  logic [7:0]      target_q;
  logic [3:0]      rate_q;
  logic [7:0]      duty_q;
  logic            bl_en_q;
  logic            done_q;

  logic       tick;
  logic       step_en;
  logic       cmd_accept;
  logic [7:0] ramp_next;
  logic [7:0] down_next;

  // One step from cur toward tgt, clamped at tgt. 9-bit math keeps the
  // comparisons free of wrap-around at either end of the duty range.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] cur9;
    logic [8:0] tgt9;
    logic [8:0] sum9;
    logic [8:0] dif9;
    cur9 = {1'b0, cur};
    tgt9 = {1'b0, tgt};
    sum9 = cur9 + Step9;
    dif9 = cur9 - Step9;
    if (cur9 < tgt9) begin
      return (sum9 >= tgt9) ? tgt : sum9[7:0];
    end else if (cur9 > tgt9) begin
      return (cur9 <= tgt9 + Step9) ? tgt : dif9[7:0];
    end
    return cur;
  endfunction

  // Free-running timebase; never cleared by state changes, so the first step
  // after entering a state can come up to one tick early.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tb_cnt_q <= '0;
    end else if (tb_cnt_q == TbLast) begin
      tb_cnt_q <= '0;
    end else begin
      tb_cnt_q <= tb_cnt_q + TbW'(1);
    end
  end

  always_comb begin
    tick        = (tb_cnt_q == TbLast);
    step_en     = (rate_q == 4'd0) || (tick && (step_cnt_q == rate_q - 4'd1));
    o_cmd_ready = (state_q != StPwrdn);
    cmd_accept  = i_cmd_valid && o_cmd_ready;
    ramp_next   = step_toward(duty_q, target_q);
    down_next   = step_toward(duty_q, 8'd0);
    o_busy      = (state_q == StPwrup) || (state_q == StRamp) || (state_q == StPwrdn);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StOff;
      dly_cnt_q  <= '0;
      step_cnt_q <= 4'd0;
      target_q   <= 8'd128;
      rate_q     <= 4'd0;
      duty_q     <= 8'd0;
      bl_en_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Commands are stored whenever accepted, even on an edge where i_en falls.
      if (cmd_accept) begin
        target_q <= i_cmd_level;
        rate_q   <= i_cmd_rate;
      end
      case (state_q)
        StOff: begin
          duty_q <= 8'd0;
          if (i_en) begin
            state_q   <= StPwrup;
            dly_cnt_q <= '0;
            bl_en_q   <= 1'b1;
          end
        end
        StPwrup: begin
          if (!i_en) begin
            state_q <= StOff;
            bl_en_q <= 1'b0;
          end else if (tick) begin
            if (dly_cnt_q == DlyLast) begin
              state_q    <= StRamp;
              step_cnt_q <= 4'd0;
            end else begin
              dly_cnt_q <= dly_cnt_q + DlyW'(1);
            end
          end
        end
        StRamp: begin
          if (!i_en) begin
            state_q    <= StPwrdn;
            step_cnt_q <= 4'd0;
          end else if (cmd_accept) begin
            // Retarget: restart the step schedule; no step toward the stale target.
            step_cnt_q <= 4'd0;
          end else if (duty_q == target_q) begin
            state_q <= StHold;
            done_q  <= 1'b1;
          end else if (step_en) begin
            duty_q     <= ramp_next;
            step_cnt_q <= 4'd0;
          end else if (tick) begin
            step_cnt_q <= step_cnt_q + 4'd1;
          end
        end
        StHold: begin
          if (!i_en) begin
            state_q    <= StPwrdn;
            step_cnt_q <= 4'd0;
          end else if (cmd_accept) begin
            if (i_cmd_level == duty_q) begin
              done_q <= 1'b1;
            end else begin
              state_q    <= StRamp;
              step_cnt_q <= 4'd0;
            end
          end
        end
        StPwrdn: begin
          // i_en is ignored here; a re-request waits for OFF and a full power-up.
          if (duty_q == 8'd0) begin
            state_q <= StOff;
            bl_en_q <= 1'b0;
          end else if (step_en) begin
            duty_q     <= down_next;
            step_cnt_q <= 4'd0;
          end else if (tick) begin
            step_cnt_q <= step_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= StOff;
          bl_en_q <= 1'b0;
          duty_q  <= 8'd0;
        end
      endcase
    end
  end

  assign o_duty  = duty_q;
  assign o_bl_en = bl_en_q;
  assign o_done  = done_q;

endmodule
